// File: rtl/cnt_sched_ctrl_pkg.sv
// Shared definitions for the counter sequencing controller.
//   state_t      : controller state encoding (2-bit binary)
//   MODE_ONESHOT : stop in DONE after the first terminal count
//   MODE_RELOAD  : clear and keep counting after each terminal count
package cnt_sched_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/cnt_sched_ctrl_if.sv
// Control/status bundle between software-facing registers and the controller.
//   start, stop, hold, mode, limit, irq_clr : control from the register side
//   count, busy, done, irq, overrun         : registered status from the controller
//   state                                   : controller state, for observation only
//
// Request semantics: start and stop are single-cycle requests sampled on the
// rising clock edge; there is no ready/acknowledge. A start seen while RUN is
// dropped, stop is always taken and wins over a coincident start. hold is a level.
interface cnt_sched_ctrl_if #(
    parameter int WIDTH = 8
) ();
    import cnt_sched_ctrl_pkg::*;

    logic             start;
    logic             stop;
    logic             hold;
    logic             mode;
    logic [WIDTH-1:0] limit;
    logic             irq_clr;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             irq;
    logic             overrun;
    state_t           state;

    modport master (
        output start, stop, hold, mode, limit, irq_clr,
        input  count, busy, done, irq, overrun, state
    );

    modport slave (
        input  start, stop, hold, mode, limit, irq_clr,
        output count, busy, done, irq, overrun, state
    );

endinterface

// File: rtl/cnt_sched_ctrl_up_counter.sv
// Plain up-counter datapath; terminal-count logic lives in the controller.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : increment by one (wraps modulo 2^WIDTH)
//   clr        : synchronous clear, takes priority over en
//   q          : counter value
module up_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q + ONE;
        end
    end

endmodule

// File: rtl/cnt_sched_ctrl.sv
// Programmable interval timer controller around up_counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : control/status bundle (slave side), see cnt_sched_ctrl_if
// The controller latches limit/mode on an accepted start, owns the counter's
// en/clr, compares the counter against the latched limit and raises a
// registered done pulse plus sticky irq/overrun flags.
module cnt_sched_ctrl
    import cnt_sched_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cnt_sched_ctrl_if.slave         bus
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] limit_q;
    logic             mode_q;
    logic             cnt_en;
    logic             cnt_clr;
    logic             done_set;
    logic             accept_start;
    logic             busy_q;
    logic             done_q;
    logic             irq_q;
    logic             overrun_q;

    up_counter #(.WIDTH(WIDTH)) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .q     (count_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_en       = 1'b0;
        cnt_clr      = 1'b0;
        done_set     = 1'b0;
        accept_start = 1'b0;
        if (bus.stop) begin
            state_next = ST_IDLE;
            cnt_clr    = 1'b1;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        accept_start = 1'b1;
                        state_next   = ST_RUN;
                        cnt_clr      = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!bus.hold) begin
                        // Compare before incrementing so the count never passes limit_q.
                        if (count_q == limit_q) begin
                            done_set = 1'b1;
                            if (mode_q == MODE_RELOAD) begin
                                cnt_clr = 1'b1;
                            end else begin
                                state_next = ST_DONE;
                            end
                        end else begin
                            cnt_en = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_clr    = 1'b1;
                end
            endcase
        end
    end

    // Status registers. A done in the same edge as irq_clr keeps irq set and
    // does not count as an overrun; irq_clr otherwise clears both flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            limit_q   <= '0;
            mode_q    <= MODE_ONESHOT;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            irq_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (accept_start) begin
                limit_q <= bus.limit;
                mode_q  <= bus.mode;
            end
            busy_q    <= (state_next == ST_RUN);
            done_q    <= done_set;
            irq_q     <= done_set | (irq_q & ~bus.irq_clr);
            overrun_q <= (done_set & irq_q & ~bus.irq_clr) | (overrun_q & ~bus.irq_clr);
        end
    end

    assign bus.count   = count_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.irq     = irq_q;
    assign bus.overrun = overrun_q;
    assign bus.state   = state;

endmodule
